// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one full cipher round per clock,
// with round counting, Rcon generation, final-round selection and load/done handshake.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] cyphertext,
  output logic [3:0]   round,
  output logic [127:0] state_dbg
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] rk_next;
  logic [127:0] sb_sr;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(b, b);
    x3   = gf_mul(x2, b);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; byte 0 occupies the top of the word.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64]  ^ n0;
    n2 = rk[63:32]  ^ n1;
    n3 = rk[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    round_d = round_q;
    rk_next = key_expand(rk_q, rcon(round_q));
    sb_sr   = shift_rows(sub_bytes(state_q));
    case (fsm_q)
      IDLE, DONE: begin
        if (load) begin
          state_d = plaintext ^ key;
          rk_d    = key;
          round_d = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (round_q < 4'(NR)) begin
          state_d = mix_columns(sb_sr) ^ rk_next;
          rk_d    = rk_next;
          round_d = round_q + 4'd1;
        end else begin
          // Final round skips mix_columns; round index stays at NR in DONE.
          state_d = sb_sr ^ rk_next;
          ct_d    = sb_sr ^ rk_next;
          fsm_d   = DONE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
      round_q <= round_d;
    end
  end

  assign busy       = (fsm_q == RUN);
  assign done       = (fsm_q == DONE);
  assign cyphertext = ct_q;
  assign round      = round_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl using FIPS-197 Appendix B and C.1 vectors.
module tb_aes_round_ctrl;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk;
  logic         reset;
  logic         load;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;
  logic [127:0] cyphertext;
  logic [3:0]   round;
  logic [127:0] state_dbg;

  int checks = 0;
  int errors = 0;

  aes_round_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .key        (key),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .cyphertext (cyphertext),
    .round      (round),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k, input logic [127:0] p);
    key       = k;
    plaintext = p;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  // Called after the load edge; counts edges (load edge = 1) and busy cycles until done.
  task automatic run_to_done(output int edges, output int busy_n);
    edges  = 1;
    busy_n = busy ? 1 : 0;
    while (!done && edges < 40) begin
      step();
      edges++;
      if (busy) busy_n++;
      if (busy && done) check("busy_done_excl", 128'(1), 128'(0));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  128'(busy),  128'(0));
    check({tag, "_done"},  128'(done),  128'(0));
    check({tag, "_ct"},    cyphertext,  128'(0));
    check({tag, "_round"}, 128'(round), 128'(0));
    check({tag, "_state"}, state_dbg,   128'(0));
  endtask

  initial begin
    int edges;
    int busy_n;
    int guard;
    reset     = 1'b1;
    load      = 1'b0;
    key       = '0;
    plaintext = '0;
    step();
    step();
    reset = 1'b0;
    check_reset_state("rst");

    // App. B with round-by-round state checks
    do_load(KB, PB);
    check("b_state1", state_dbg, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("b_round1", 128'(round), 128'(1));
    check("b_busy1",  128'(busy),  128'(1));
    check("b_ct_hold", cyphertext, 128'(0));
    step();
    check("b_state2", state_dbg, 128'ha49c7ff2689f352b6b5bea43026a5049);
    check("b_round2", 128'(round), 128'(2));
    edges  = 2;
    busy_n = 2;
    while (!done && edges < 40) begin
      step();
      edges++;
      if (busy) busy_n++;
    end
    check("b_edges", 128'(edges), 128'(11));
    check("b_ct",    cyphertext,  CB);
    check("b_round10", 128'(round), 128'(10));
    check("b_busy_n", 128'(busy_n), 128'(10));

    // App. C.1
    do_load(KC, PC);
    check("c_done_clr", 128'(done), 128'(0));
    check("c_ct_prev",  cyphertext, CB);
    run_to_done(edges, busy_n);
    check("c_edges",  128'(edges),  128'(11));
    check("c_busy_n", 128'(busy_n), 128'(10));
    check("c_ct",     cyphertext,   CC);

    // Load pulse during RUN must be ignored
    do_load(KB, PB);
    edges = 1;
    guard = 0;
    while (round != 4'd5 && guard < 20) begin
      step();
      edges++;
      guard++;
    end
    check("ign_reach_r5", 128'(round), 128'(5));
    key       = KC;
    plaintext = PC;
    load      = 1'b1;
    step();
    edges++;
    load = 1'b0;
    check("ign_round6", 128'(round), 128'(6));
    while (!done && edges < 40) begin
      step();
      edges++;
    end
    check("ign_edges", 128'(edges), 128'(11));
    check("ign_ct",    cyphertext,  CB);

    // Hold in DONE
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_done", 128'(done), 128'(1));
      check("hold_ct",   cyphertext, CB);
    end

    // Back-to-back with load held high: done every 11 edges for one cycle
    key       = KC;
    plaintext = PC;
    load      = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step();
      check("b2b_done", 128'(done), 128'((k % 11) == 0));
      check("b2b_ct",   cyphertext, (k < 11) ? CB : CC);
      check("b2b_busy", 128'(busy), 128'((k % 11) != 0));
    end
    load = 1'b0;

    // Reset mid-operation at round 6
    do_load(KB, PB);
    guard = 0;
    while (round != 4'd6 && guard < 20) begin
      step();
      guard++;
    end
    check("mid_reach_r6", 128'(round), 128'(6));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("mid");
    do_load(KC, PC);
    run_to_done(edges, busy_n);
    check("mid_edges", 128'(edges), 128'(11));
    check("mid_ct",    cyphertext,  CC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
